tc_bank: RTL and testbench

TC_BANK -- requirements
Module: tc_bank

---
 rtl/tc_bank.sv | 194 +++++++++++++++++++
 tb/tb_tc_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tc_bank                                                        |
// | Summary  : bank of NUM_CH independent down-counting timers with per-     |
// |            channel CTRL/PRESET/COUNT/STATUS registers and masked IRQs.   |
// |            Optional macro TC_BANK_PRESCALE_EN adds an 8-bit prescaler     |
// |            per channel, configured through CTRL[15:8].                    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tc_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

`ifdef TC_BANK_PRESCALE_EN
  localparam logic [15:0] CTRL_MASK = 16'hFF0F;
`else
  localparam logic [15:0] CTRL_MASK = 16'h000F;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  logic [1:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data [NUM_CH];
  logic        unused_din;

  assign ch_sel     = Addr[3:2];
  assign reg_sel    = Addr[1:0];
  // Upper Din bits only matter for some CNT_W / macro settings.
  assign unused_din = ^Din;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [15:0]      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
`ifdef TC_BANK_PRESCALE_EN
    logic [7:0]       psc_q, psc_d;
`endif
    logic             sel;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             wr_status;
    logic             en;
    logic [1:0]       mode;
    logic             cnt_zero;
    logic [31:0]      rd_w;

    assign sel       = (ch_sel == 2'(i));
    assign wr_ctrl   = WE & sel & (reg_sel == REG_CTRL);
    assign wr_preset = WE & sel & (reg_sel == REG_PRESET);
    assign wr_status = WE & sel & (reg_sel == REG_STATUS);
    assign en        = ctrl_q[0];
    assign mode      = ctrl_q[2:1];
    assign cnt_zero  = (count_q == '0);

    always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;
`ifdef TC_BANK_PRESCALE_EN
      psc_d    = psc_q;
`endif

      // Clear first so a same-edge hardware set below takes priority.
      if (wr_status && Din[0]) begin
        pend_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_d = preset_q;
`ifdef TC_BANK_PRESCALE_EN
          psc_d   = '0;
`endif
          state_d = ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else if (!cnt_zero) begin
`ifdef TC_BANK_PRESCALE_EN
            if (psc_q == ctrl_q[15:8]) begin
              count_d = count_q - CNT_ONE;
              psc_d   = '0;
            end else begin
              psc_d   = psc_q + 8'd1;
            end
`else
            count_d = count_q - CNT_ONE;
`endif
          end else begin
            state_d = ST_INT;
            pend_d  = 1'b1;
          end
        end
        ST_INT: begin
          if (en && (mode == 2'b01)) begin
            state_d = ST_LOAD;
          end else begin
            ctrl_d[0] = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Software writes come last so they override the hardware EN clear.
      if (wr_ctrl) begin
        ctrl_d = Din[15:0] & CTRL_MASK;
      end
      if (wr_preset) begin
        preset_d = Din[CNT_W-1:0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        ctrl_q   <= '0;
        preset_q <= '0;
        count_q  <= '0;
        pend_q   <= 1'b0;
`ifdef TC_BANK_PRESCALE_EN
        psc_q    <= '0;
`endif
      end else begin
        state_q  <= state_d;
        ctrl_q   <= ctrl_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        pend_q   <= pend_d;
`ifdef TC_BANK_PRESCALE_EN
        psc_q    <= psc_d;
`endif
      end
    end

    always_comb begin
      case (reg_sel)
        REG_CTRL:   rd_w = {16'h0000, ctrl_q};
        REG_PRESET: rd_w = 32'(preset_q);
        REG_COUNT:  rd_w = 32'(count_q);
        default:    rd_w = {31'h0, pend_q};
      endcase
    end

    assign rd_data[i] = rd_w;
    assign IRQ[i]     = pend_q & ctrl_q[3];
  end

  // Channels at or beyond NUM_CH fall through to zero.
  always_comb begin
    Dout = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (ch_sel == 2'(j)) begin
        Dout = rd_data[j];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tc_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tc_bank                                                     |
// | Summary  : self-checking bench for tc_bank; register vectors plus timed   |
// |            interrupt sequences checked through a scoreboard queue.        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tc_bank;

`ifdef TC_BANK_PRESCALE_EN
  localparam int          CW         = 16;
  localparam logic [31:0] CTRL_RMASK = 32'h0000_FF0F;
`else
  localparam int          CW         = 32;
  localparam logic [31:0] CTRL_RMASK = 32'h0000_000F;
`endif
  localparam int          NCH      = 2;
  localparam logic [31:0] CNT_MASK = (CW == 32) ? 32'hFFFF_FFFF : ((32'h1 << CW) - 32'h1);

  logic           clk;
  logic           reset;
  logic [3:0]     Addr;
  logic           WE;
  logic [31:0]    Din;
  logic [31:0]    Dout;
  logic [NCH-1:0] IRQ;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;

  logic [31:0] sb_q[$];
  int          ev_q[$];

  typedef struct {
    logic        do_wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  tc_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int e);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    step();
    WE   = 1'b0;
    Din  = '0;
    e    = edge_cnt;
  endtask

  task automatic rd_check(input string nm, input logic [3:0] a, input logic [31:0] e);
    sb_q.push_back(e);
    Addr = a;
    #1;
    chk(nm, Dout, sb_q.pop_front());
  endtask

  task automatic wait_irq(input int ch, input int budget, output int e);
    e = -1;
    for (int k = 0; k <= budget; k++) begin
      if (IRQ[ch]) begin
        e = edge_cnt;
        break;
      end
      step();
    end
  endtask

  task automatic chk_ev(input string nm, input int got);
    chk(nm, 32'(got), 32'(ev_q.pop_front()));
  endtask

  initial begin
    int w, w2, e, dummy;
    logic irq_seen;

    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    step();
    step();
    rd_check("rst_ctrl0", 4'h0, 32'h0);
    rd_check("rst_status1", 4'h7, 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    reset = 1'b0;
    step();

    // Register access vectors; all keep EN=0 so nothing counts.
    vecs[0]  = '{1'b1, 4'h1, 32'hDEAD_BEEF, 4'h1, 32'hDEAD_BEEF & CNT_MASK, "preset0_rw"};
    vecs[1]  = '{1'b1, 4'h0, 32'hFFFF_FFF6, 4'h0, 32'hFFFF_FFF6 & CTRL_RMASK, "ctrl0_reserved"};
    vecs[2]  = '{1'b1, 4'h2, 32'h0000_0055, 4'h2, 32'h0, "count0_wr_ignored"};
    vecs[3]  = '{1'b1, 4'h5, 32'h0000_0012, 4'h5, 32'h12, "preset1_rw"};
    vecs[4]  = '{1'b0, 4'h0, 32'h0, 4'h1, 32'hDEAD_BEEF & CNT_MASK, "preset0_kept"};
    vecs[5]  = '{1'b1, 4'hD, 32'h0000_0077, 4'hD, 32'h0, "ch3_preset_rd0"};
    vecs[6]  = '{1'b1, 4'h8, 32'h0000_0009, 4'h8, 32'h0, "ch2_ctrl_rd0"};
    vecs[7]  = '{1'b1, 4'h3, 32'h0000_0001, 4'h3, 32'h0, "status0_w1c_idle"};
    vecs[8]  = '{1'b1, 4'h0, 32'h0, 4'h0, 32'h0, "ctrl0_clear"};
    vecs[9]  = '{1'b1, 4'h1, 32'h0, 4'h1, 32'h0, "preset0_clear"};
    vecs[10] = '{1'b1, 4'h5, 32'h0, 4'h5, 32'h0, "preset1_clear"};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata, dummy);
      rd_check(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end
    chk("vec_irq_quiet", 32'(IRQ), 32'h0);

    // One-shot: PRESET=3 -> IRQ 6 edges after enable.
    wr(4'h1, 32'd3, dummy);
    wr(4'h0, 32'h9, w);
    ev_q.push_back(w + 6);
    wait_irq(0, 30, e);
    chk_ev("oneshot_latency", e);
    step();
    rd_check("oneshot_en_cleared", 4'h0, 32'h8);
    rd_check("oneshot_count0", 4'h2, 32'h0);
    repeat (3) step();
    chk("oneshot_irq_held", 32'(IRQ[0]), 32'h1);
    wr(4'h3, 32'h1, dummy);
    chk("oneshot_irq_cleared", 32'(IRQ[0]), 32'h0);

    // Auto-reload on ch1: set events every PRESET+3 = 5 edges.
    wr(4'h5, 32'd2, dummy);
    wr(4'h4, 32'hB, w);
    for (int k = 1; k <= 3; k++) begin
      ev_q.push_back(w + 5 * k);
      wait_irq(1, 30, e);
      chk_ev($sformatf("autoreload_period%0d", k), e);
      wr(4'h7, 32'h1, dummy);
    end
    chk("autoreload_ch0_quiet", 32'(IRQ[0]), 32'h0);
    wr(4'h4, 32'h0, dummy);
    wr(4'h7, 32'h1, dummy);
    chk("autoreload_irq_off", 32'(IRQ[1]), 32'h0);

    // Collision: W1C lands on the PEND-set edge (enable edge + 4), IM=0.
    wr(4'h1, 32'd1, dummy);
    wr(4'h0, 32'h1, w);
    repeat (3) step();
    wr(4'h3, 32'h1, dummy);
    rd_check("collision_pend_kept", 4'h3, 32'h1);
    chk("collision_irq_masked", 32'(IRQ[0]), 32'h0);
    wr(4'h3, 32'h1, dummy);
    rd_check("collision_pend_cleared", 4'h3, 32'h0);

    // PRESET=0 latency, then a CTRL write on the hardware EN-clear edge.
    wr(4'h1, 32'd0, dummy);
    wr(4'h0, 32'h9, w);
    ev_q.push_back(w + 3);
    wait_irq(0, 30, e);
    chk_ev("preset0_latency", e);
    wr(4'h0, 32'h9, w2);
    rd_check("sw_ctrl_wins", 4'h0, 32'h9);
    wr(4'h3, 32'h1, dummy);
    ev_q.push_back(w2 + 3);
    wait_irq(0, 30, e);
    chk_ev("restart_latency", e);
    wr(4'h0, 32'h0, dummy);
    wr(4'h3, 32'h1, dummy);

    // Disable mid-count: the write edge still decrements 6->5, then COUNT holds.
    wr(4'h1, 32'd10, dummy);
    wr(4'h0, 32'h1, w);
    repeat (6) step();
    wr(4'h0, 32'h0, dummy);
    repeat (3) step();
    rd_check("disable_count_hold", 4'h2, 32'd5);
    wr(4'h2, 32'h99, dummy);
    rd_check("count_wr_ignored_hold", 4'h2, 32'd5);
    rd_check("ch3_count_rd0", 4'hE, 32'h0);

    // Asynchronous reset mid-count at COUNT=7.
    wr(4'h1, 32'd20, dummy);
    wr(4'h0, 32'h9, w);
    repeat (15) step();
    rd_check("pre_reset_count7", 4'h2, 32'd7);
    reset = 1'b1;
    #1;
    rd_check("async_rst_ctrl", 4'h0, 32'h0);
    rd_check("async_rst_preset", 4'h1, 32'h0);
    rd_check("async_rst_count", 4'h2, 32'h0);
    chk("async_rst_irq", 32'(IRQ), 32'h0);
    step();
    step();
    reset = 1'b0;
    irq_seen = 1'b0;
    repeat (20) begin
      step();
      if (IRQ != '0) irq_seen = 1'b1;
    end
    chk("no_irq_after_reset", 32'(irq_seen), 32'h0);
    rd_check("post_reset_status", 4'h3, 32'h0);

`ifdef TC_BANK_PRESCALE_EN
    // Prescaler: PRESET=2, PS=3 -> PEND after 2*(3+1)+3 = 11 edges.
    wr(4'h1, 32'h0001_2345, dummy);
    rd_check("preset_truncated", 4'h1, 32'h0000_2345);
    wr(4'h1, 32'd2, dummy);
    wr(4'h0, 32'h0000_0309, w);
    ev_q.push_back(w + 11);
    wait_irq(0, 40, e);
    chk_ev("prescale_latency", e);
    wr(4'h3, 32'h1, dummy);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
